// File: rtl/apb_timer_core.sv
// Prescaled down-counting timer with one-shot / auto-reload modes.
// The live count feeds PRDATA; expiry yields a one-cycle pulse plus a sticky irq.
module apb_timer_core #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic [WIDTH-1:0] timer_in,
   input  logic             load,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] out,
   output logic             running,
   output logic             expired,
   output logic             irq
);

   localparam int PSC_W = $clog2(PRESCALE) + 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             running_q, running_d;
   logic             exp_q, exp_d;
   logic             irq_q, irq_d;
   logic             tick;

   assign tick = (state_q == RUN) && (psc_q == PSC_LAST);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         reload_q  <= '0;
         cnt_q     <= '0;
         psc_q     <= '0;
         running_q <= 1'b0;
         exp_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         reload_q  <= reload_d;
         cnt_q     <= cnt_d;
         psc_q     <= psc_d;
         running_q <= running_d;
         exp_q     <= exp_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      reload_d = reload_q;
      cnt_d    = cnt_q;
      psc_d    = psc_q;
      exp_d    = 1'b0;
      irq_d    = irq_q & ~irq_clr;

      if (load) begin
         // Load suppresses this cycle's tick; stop still overrides start.
         reload_d = timer_in;
         cnt_d    = timer_in;
         psc_d    = '0;
         if (stop)
            state_d = IDLE;
         else if (start)
            state_d = RUN;
         else
            state_d = (state_q == RUN) ? RUN : IDLE;
      end else if (stop && (state_q == RUN)) begin
         state_d = IDLE;
         psc_d   = '0;
      end else if (start && !stop && (state_q != RUN)) begin
         state_d = RUN;
         psc_d   = '0;
         if (state_q == DONE)
            cnt_d = reload_q;
      end else if (state_q == RUN) begin
         if (tick) begin
            psc_d = '0;
            if (cnt_q > WIDTH'(1)) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else begin
               // Counts of 0 and 1 both expire, so reload=0 fires every tick.
               exp_d = 1'b1;
               irq_d = 1'b1;
               if (auto_reload) begin
                  cnt_d = reload_q;
               end else begin
                  cnt_d   = '0;
                  state_d = DONE;
               end
            end
         end else begin
            psc_d = psc_q + PSC_W'(1);
         end
      end else begin
         psc_d = '0;
      end

      running_d = (state_d == RUN);
   end

   assign out     = cnt_q;
   assign running = running_q;
   assign expired = exp_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_apb_timer_core.sv
// Directed bench: stimulus queues per-edge expectations, a negedge monitor checks them.
module tb_apb_timer_core;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic [7:0] timer_in;
   logic       load, start, stop, auto_reload, irq_clr;
   logic [7:0] out;
   logic       running, expired, irq;

   apb_timer_core #(.WIDTH(8), .PRESCALE(4)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .timer_in(timer_in), .load(load),
      .start(start), .stop(stop), .auto_reload(auto_reload), .irq_clr(irq_clr),
      .out(out), .running(running), .expired(expired), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      int         cyc;
      logic [7:0] out;
      logic       run;
      logic       exp;
      logic       irq;
      string      nm;
   } chk_t;

   chk_t q[$];
   int   ec = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge PCLK) ec <= ec + 1;

   // Monitor: compare every expectation tagged for the edge just completed.
   always @(negedge PCLK) begin
      while (q.size() > 0 && q[0].cyc <= ec) begin
         chk_t c;
         c = q.pop_front();
         total++;
         if ({out, running, expired, irq} !== {c.out, c.run, c.exp, c.irq}) begin
            bad++;
            $display("FAIL %s edge=%0d got out=%0d run=%b exp=%b irq=%b want out=%0d run=%b exp=%b irq=%b",
                     c.nm, ec, out, running, expired, irq, c.out, c.run, c.exp, c.irq);
         end
      end
   end

   task automatic push_chk(input int cyc, input logic [7:0] o, input logic r,
                           input logic e, input logic i, input string nm);
      chk_t c;
      c.cyc = cyc; c.out = o; c.run = r; c.exp = e; c.irq = i; c.nm = nm;
      q.push_back(c);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   int base;

   initial begin
      // Reset with junk on every input
      PRESETn     = 1'b0;
      timer_in    = 8'($urandom);
      load        = 1'($urandom);
      start       = 1'($urandom);
      stop        = 1'($urandom);
      auto_reload = 1'($urandom);
      irq_clr     = 1'($urandom);
      push_chk(1, 8'd0, 0, 0, 0, "reset1");
      push_chk(2, 8'd0, 0, 0, 0, "reset2");
      step(2);
      PRESETn = 1'b1; timer_in = 0; load = 0; start = 0; stop = 0;
      auto_reload = 0; irq_clr = 0;

      // One-shot: load 3 then start
      timer_in = 8'd3; load = 1'b1;
      step(1); load = 1'b0;
      push_chk(ec, 8'd3, 0, 0, 0, "os_load");
      start = 1'b1;
      step(1); start = 1'b0;
      base = ec;
      for (int k = 0; k <= 13; k++)
         push_chk(base + k, (k < 4) ? 8'd3 : (k < 8) ? 8'd2 : (k < 12) ? 8'd1 : 8'd0,
                  k < 12, k == 12, k >= 12, "oneshot");
      step(14);

      // Periodic: load 2 (leaves DONE), clear irq, start
      timer_in = 8'd2; load = 1'b1; auto_reload = 1'b1; irq_clr = 1'b1;
      step(1); load = 1'b0; irq_clr = 1'b0;
      push_chk(ec, 8'd2, 0, 0, 0, "per_load");
      start = 1'b1;
      step(1); start = 1'b0;
      base = ec;
      for (int k = 0; k <= 27; k++)
         push_chk(base + k, (((k / 4) % 2) == 0) ? 8'd2 : 8'd1, 1,
                  (k > 0) && (k % 8 == 0), k >= 8, "periodic");
      step(27);
      irq_clr = 1'b1;
      push_chk(base + 28, 8'd1, 1, 0, 0, "irq_clr");
      step(1); irq_clr = 1'b0;
      for (int k = 29; k <= 31; k++)
         push_chk(base + k, 8'd1, 1, 0, 0, "per_noirq");
      push_chk(base + 32, 8'd2, 1, 1, 1, "clr_on_exp");
      step(3);
      irq_clr = 1'b1;
      step(1); irq_clr = 1'b0;
      stop = 1'b1; start = 1'b1;
      for (int k = 33; k <= 35; k++)
         push_chk(base + k, 8'd2, 0, 0, 1, "stop_start");
      step(1); stop = 1'b0; start = 1'b0;
      step(2);

      // Pause: load 5, start, stop 6 edges later, resume
      timer_in = 8'd5; load = 1'b1; auto_reload = 1'b0;
      step(1); load = 1'b0;
      start = 1'b1;
      step(1); start = 1'b0;
      base = ec;
      for (int k = 0; k <= 5; k++)
         push_chk(base + k, (k < 4) ? 8'd5 : 8'd4, 1, 0, 1, "pause_run");
      for (int k = 6; k <= 9; k++)
         push_chk(base + k, 8'd4, 0, 0, 1, "paused");
      step(5);
      stop = 1'b1;
      step(1); stop = 1'b0;
      step(3);
      start = 1'b1;
      step(1); start = 1'b0;
      base = ec;
      for (int k = 0; k <= 3; k++)
         push_chk(base + k, 8'd4, 1, 0, 1, "resume");
      // Ticks at +4,+8,+12; +16 would expire but load 7 wins
      for (int k = 4; k <= 20; k++)
         push_chk(base + k, (k < 8) ? 8'd3 : (k < 12) ? 8'd2 : (k < 16) ? 8'd1 :
                  (k < 20) ? 8'd7 : 8'd6, 1, 0, 1, "load_on_tick");
      step(15);
      timer_in = 8'd7; load = 1'b1;
      step(1); load = 1'b0;
      step(4);

      // Reset mid-run with out=2, then start with reload=0
      timer_in = 8'd2; load = 1'b1;
      push_chk(ec + 1, 8'd2, 1, 0, 1, "pre_rst");
      step(1); load = 1'b0;
      PRESETn = 1'b0;
      push_chk(ec + 1, 8'd0, 0, 0, 0, "mid_rst");
      step(1); PRESETn = 1'b1;
      start = 1'b1;
      step(1); start = 1'b0;
      base = ec;
      for (int k = 0; k <= 3; k++)
         push_chk(base + k, 8'd0, 1, 0, 0, "zero_run");
      push_chk(base + 4, 8'd0, 0, 1, 1, "zero_exp");
      push_chk(base + 5, 8'd0, 0, 0, 1, "zero_done");
      step(6);

      for (int w = 0; w < 50 && q.size() > 0; w++) step(1);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
